sdl_video_bridge: RTL and testbench

Parametrised successor to the fixed 800x600 simulation display path. Generates raster timing and pixel coordinates for a game core, realigns the core's colour output through a configurable-latency delay line, and drives a registered SDL pixel stream to the Verilator frontend. Replaces the fixed-timing controller plus output flop stage: supports any resolution/porch set, any core pixel latency, and generalised colour-depth expansion.

---
 rtl/sdl_video_bridge.sv | 178 +++++++++++++++++
 tb/tb_sdl_video_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdl_video_bridge.sv
// Raster timing generator with core-latency realignment and registered SDL pixel stream.
// Optional frame counter output enabled by defining SDL_FRAME_COUNT_EN.
module sdl_video_bridge #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 72,
  parameter int unsigned H_BP        = 128,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned V_FP        = 1,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 22,
  parameter int unsigned COLOR_IN_W  = 4,
  parameter int unsigned COLOR_OUT_W = 8,
  parameter int unsigned PIPE_LAT    = 0
) (
  input  logic                   pixel_clk,
  input  logic                   sim_rst,
  output logic [10:0]            h_coord,
  output logic [9:0]             v_coord,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   disp_enbl,
  input  logic [COLOR_IN_W-1:0]  red,
  input  logic [COLOR_IN_W-1:0]  green,
  input  logic [COLOR_IN_W-1:0]  blue,
  output logic [10:0]            sdl_sx,
  output logic [9:0]             sdl_sy,
  output logic                   sdl_de,
  output logic [COLOR_OUT_W-1:0] sdl_r,
  output logic [COLOR_OUT_W-1:0] sdl_g,
  output logic [COLOR_OUT_W-1:0] sdl_b,
`ifdef SDL_FRAME_COUNT_EN
  output logic [31:0]            sdl_frame_cnt,
`endif
  output logic                   sdl_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (COLOR_OUT_W < COLOR_IN_W || PIPE_LAT > 15) begin : g_bad_cfg
    $error("sdl_video_bridge: COLOR_OUT_W must be >= COLOR_IN_W and PIPE_LAT <= 15");
  end

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        de;
  } tap_t;

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == 11'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sim_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_coord   = h_q;
  assign v_coord   = v_q;
  assign disp_enbl = (h_q < 11'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
  assign h_sync    = (h_q >= 11'(H_ACTIVE + H_FP)) && (h_q < 11'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync    = (v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC));

  tap_t tap_in, tap_out;
  assign tap_in = '{h: h_q, v: v_q, de: disp_enbl};

  // Coordinates travel alongside the core's pipeline so they meet its colour output.
  if (PIPE_LAT == 0) begin : g_nodly
    assign tap_out = tap_in;
  end else begin : g_dly
    tap_t pipe_q [PIPE_LAT];
    tap_t pipe_d [PIPE_LAT];

    always_comb begin
      pipe_d[0] = tap_in;
      for (int unsigned i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge pixel_clk) begin
      if (sim_rst) begin
        for (int unsigned i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < PIPE_LAT; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign tap_out = pipe_q[PIPE_LAT-1];
  end

  // Bit replication, MSB-first, truncated to the output width.
  function automatic logic [COLOR_OUT_W-1:0] expand(input logic [COLOR_IN_W-1:0] c);
    logic [COLOR_OUT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < COLOR_OUT_W; i++)
      r[COLOR_OUT_W-1-i] = c[COLOR_IN_W-1-(i % COLOR_IN_W)];
    return r;
  endfunction

  logic [10:0]            sx_q, sx_d;
  logic [9:0]             sy_q, sy_d;
  logic                   de_q, de_d;
  logic [COLOR_OUT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   frame_start_q, frame_start_d;

  always_comb begin
    sx_d          = tap_out.h;
    sy_d          = tap_out.v;
    de_d          = tap_out.de;
    r_d           = '0;
    g_d           = '0;
    b_d           = '0;
    frame_start_d = tap_out.de && (tap_out.h == '0) && (tap_out.v == '0);
    if (tap_out.de) begin
      r_d = expand(red);
      g_d = expand(green);
      b_d = expand(blue);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sim_rst) begin
      sx_q          <= '0;
      sy_q          <= '0;
      de_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      de_q          <= de_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sdl_sx          = sx_q;
  assign sdl_sy          = sy_q;
  assign sdl_de          = de_q;
  assign sdl_r           = r_q;
  assign sdl_g           = g_q;
  assign sdl_b           = b_q;
  assign sdl_frame_start = frame_start_q;

`ifdef SDL_FRAME_COUNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {31'b0, frame_start_q};
  end

  always_ff @(posedge pixel_clk) begin
    if (sim_rst) frame_cnt_q <= '0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign sdl_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sdl_video_bridge.sv
// Bench for sdl_video_bridge: a small-raster instance (PIPE_LAT=3, 5->8 colour) and a
// default-parameter instance (PIPE_LAT=0, 4->8 colour), checked against an arithmetic raster model.
module tb_sdl_video_bridge;

  localparam int AHA = 16, AHF = 2, AHS = 3, AHB = 3;
  localparam int AVA = 8,  AVF = 1, AVS = 2, AVB = 2;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  localparam int AL  = 3;
  localparam int RUN = 1100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] a_h, a_sx, b_h, b_sx;
  logic [9:0]  a_v, a_sy, b_v, b_sy;
  logic        a_hs, a_vs, a_de, a_sde, a_fs;
  logic        b_hs, b_vs, b_de, b_sde, b_fs;
  logic [4:0]  a_r, a_g, a_b;
  logic [3:0]  b_r, b_g, b_b;
  logic [7:0]  a_sr, a_sg, a_sb, b_sr, b_sg, b_sb;
`ifdef SDL_FRAME_COUNT_EN
  logic [31:0] a_cnt, b_cnt;
`endif

  sdl_video_bridge #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .COLOR_IN_W(5), .COLOR_OUT_W(8), .PIPE_LAT(AL)
  ) dut_a (
    .pixel_clk(clk), .sim_rst(rst),
    .h_coord(a_h), .v_coord(a_v), .h_sync(a_hs), .v_sync(a_vs), .disp_enbl(a_de),
    .red(a_r), .green(a_g), .blue(a_b),
    .sdl_sx(a_sx), .sdl_sy(a_sy), .sdl_de(a_sde),
    .sdl_r(a_sr), .sdl_g(a_sg), .sdl_b(a_sb),
`ifdef SDL_FRAME_COUNT_EN
    .sdl_frame_cnt(a_cnt),
`endif
    .sdl_frame_start(a_fs)
  );

  sdl_video_bridge dut_b (
    .pixel_clk(clk), .sim_rst(rst),
    .h_coord(b_h), .v_coord(b_v), .h_sync(b_hs), .v_sync(b_vs), .disp_enbl(b_de),
    .red(b_r), .green(b_g), .blue(b_b),
    .sdl_sx(b_sx), .sdl_sy(b_sy), .sdl_de(b_sde),
    .sdl_r(b_sr), .sdl_g(b_sg), .sdl_b(b_sb),
`ifdef SDL_FRAME_COUNT_EN
    .sdl_frame_cnt(b_cnt),
`endif
    .sdl_frame_start(b_fs)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Replicate the input value end to end until wide enough, then keep the top 8 bits.
  function automatic logic [7:0] ref_expand(input int unsigned c, input int unsigned win);
    longint unsigned acc;
    int unsigned     bits;
    acc  = 0;
    bits = 0;
    while (bits < 8) begin
      acc  = (acc << win) | longint'(c);
      bits = bits + win;
    end
    return 8'(acc >> (bits - 8));
  endfunction

  typedef struct {
    logic [3:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t tbl [6];
  int   col_r [RUN];
  int   col_g [RUN];
  int   col_b [RUN];

  initial begin
    int ah, av, j, sx, sy, bh, bv, bsx, bsy, na, nb;
    logic ade, ahs, avs, sde, fs, bde, bsde, bfs;
    logic [7:0] er, eg, eb;
`ifdef SDL_FRAME_COUNT_EN
    int fcnt;
`endif

    tbl[0] = '{4'hA, 4'h3, 4'hF, 8'hAA, 8'h33, 8'hFF};
    tbl[1] = '{4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{4'hF, 4'hF, 4'hF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{4'h1, 4'h8, 4'hE, 8'h11, 8'h88, 8'hEE};
    tbl[4] = '{4'h5, 4'hC, 4'h7, 8'h55, 8'hCC, 8'h77};
    tbl[5] = '{4'h9, 4'h2, 4'h6, 8'h99, 8'h22, 8'h66};

    a_r = '0; a_g = '0; a_b = '0;
    b_r = '0; b_g = '0; b_b = '0;

    // Reset state and table-driven colour expansion on the zero-latency instance.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_raster", {a_h, a_v, a_de, a_hs, a_vs}, {11'd0, 10'd0, 1'b1, 1'b0, 1'b0});
    chk("reset_a_sdl", {a_sx, a_sy, a_sde, a_sr, a_sg, a_sb, a_fs}, '0);
    chk("reset_b_raster", {b_h, b_v, b_de, b_hs, b_vs}, {11'd0, 10'd0, 1'b1, 1'b0, 1'b0});
    chk("reset_b_sdl", {b_sx, b_sy, b_sde, b_sr, b_sg, b_sb, b_fs}, '0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_r = tbl[i].r; b_g = tbl[i].g; b_b = tbl[i].b;
      @(posedge clk);
      #1;
      chk("tbl_b_coord", {b_sx, b_sy, b_sde, b_fs}, {11'(i), 10'd0, 1'b1, 1'(i == 0)});
      chk("tbl_b_colour", {b_sr, b_sg, b_sb}, {tbl[i].er, tbl[i].eg, tbl[i].eb});
    end

    // Randomized run against the arithmetic raster model.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    b_r = 4'hA; b_g = 4'h3; b_b = 4'hF;
`ifdef SDL_FRAME_COUNT_EN
    fcnt = 0;
`endif
    for (int k = 0; k < RUN; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      ah  = k % AHT;
      av  = (k / AHT) % AVT;
      ade = (ah < AHA) && (av < AVA);
      ahs = (ah >= AHA + AHF) && (ah < AHA + AHF + AHS);
      avs = (av >= AVA + AVF) && (av < AVA + AVF + AVS);
      chk("a_raster", {a_h, a_v, a_de, a_hs, a_vs}, {11'(ah), 10'(av), ade, ahs, avs});

      j = k - AL - 1;
      if (j < 0) begin
        sx = 0; sy = 0; sde = 1'b0;
      end else begin
        sx  = j % AHT;
        sy  = (j / AHT) % AVT;
        sde = (sx < AHA) && (sy < AVA);
      end
      fs = sde && sx == 0 && sy == 0;
      er = 8'h00; eg = 8'h00; eb = 8'h00;
      if (sde) begin
        er = ref_expand(col_r[k-1], 5);
        eg = ref_expand(col_g[k-1], 5);
        eb = ref_expand(col_b[k-1], 5);
      end
      chk("a_sdl_coord", {a_sx, a_sy, a_sde, a_fs}, {11'(sx), 10'(sy), sde, fs});
      chk("a_sdl_colour", {a_sr, a_sg, a_sb}, {er, eg, eb});
`ifdef SDL_FRAME_COUNT_EN
      chk("a_frame_cnt", a_cnt, 64'(fcnt));
      if (fs) fcnt++;
`endif

      bh  = k % 1024;
      bv  = k / 1024;
      bde = bh < 800;
      chk("b_raster", {b_h, b_v, b_de, b_hs, b_vs},
          {11'(bh), 10'(bv), bde, 1'(bh >= 824 && bh < 896), 1'b0});
      if (k == 0) begin
        bsx = 0; bsy = 0; bsde = 1'b0;
      end else begin
        bsx  = (k - 1) % 1024;
        bsy  = (k - 1) / 1024;
        bsde = bsx < 800;
      end
      bfs = bsde && bsx == 0 && bsy == 0;
      chk("b_sdl", {b_sx, b_sy, b_sde, b_fs, b_sr, b_sg, b_sb},
          {11'(bsx), 10'(bsy), bsde, bfs,
           bsde ? 8'hAA : 8'h00, bsde ? 8'h33 : 8'h00, bsde ? 8'hFF : 8'h00});

      col_r[k] = int'($urandom_range(0, 31));
      col_g[k] = int'($urandom_range(0, 31));
      col_b[k] = int'($urandom_range(0, 31));
      a_r = 5'(col_r[k]); a_g = 5'(col_g[k]); a_b = 5'(col_b[k]);
    end

    // Mid-line reset, then frame-start latency after release.
    chk("pre_reset_b_active", {b_sde, 1'(b_sx != 0)}, 2'b11);
    rst = 1'b1;
    a_r = 5'b10110;
    @(posedge clk);
    #1;
    chk("midrst_a_counters", {a_h, a_v}, '0);
    chk("midrst_a_sdl", {a_sx, a_sy, a_sde, a_sr, a_sg, a_sb, a_fs}, '0);
    chk("midrst_b_counters", {b_h, b_v}, '0);
    chk("midrst_b_sdl", {b_sx, b_sy, b_sde, b_sr, b_sg, b_sb, b_fs}, '0);
`ifdef SDL_FRAME_COUNT_EN
    chk("midrst_cnt", {a_cnt, b_cnt}, '0);
`endif
    rst = 1'b0;
    na = 0;
    nb = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (a_fs && na == 0) na = n;
      if (b_fs && nb == 0) nb = n;
      if (n == AL + 1)
        chk("a_5bit_expand", a_sr, 8'b10110101);
    end
    chk("a_fs_latency", 64'(na), 64'(AL + 1));
    chk("b_fs_latency", 64'(nb), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
